// File: rtl/pci_arbiter_rr_if.sv
// rtl/pci_arbiter_rr_if.sv - request/grant and shared FRAME/IRDY lines of the PCI arbiter
// All signals are active low; master is the arbiter side, slave is the device side.
interface pci_arbiter_rr_if #(
  parameter int NUM_MASTERS = 5
);
  logic [NUM_MASTERS-1:0] requests;
  logic [NUM_MASTERS-1:0] grants;
  logic                   iframe;
  logic                   iready;

  modport master (
    input  requests,
    input  iframe,
    input  iready,
    output grants
  );

  modport slave (
    output requests,
    output iframe,
    output iready,
    input  grants
  );
endinterface

// File: rtl/pci_arbiter_rr.sv
// rtl/pci_arbiter_rr.sv - round-robin PCI bus arbiter with a dead cycle between owners
// Optional grant-abandon timer is compiled in when PCI_ARB_TIMEOUT_EN is defined.
module pci_arbiter_rr #(
  parameter int NUM_MASTERS = 5,
  parameter int TIMEOUT     = 16,
  localparam int OW         = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  pci_arbiter_rr_if.master bus,
  output logic [OW-1:0]   owner,
  output logic            bus_busy,
  output logic            timeout
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
    $error("pci_arbiter_rr: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    DEAD  = 2'd3
  } state_t;

  localparam logic [NUM_MASTERS-1:0] ALL_HIGH = '1;
  localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grants_q, grants_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          last_q, last_d;
`ifdef PCI_ARB_TIMEOUT_EN
  logic [7:0]             timer_q, timer_d;
  logic                   timeout_q, timeout_d;
`endif

  logic                   any_req;
  logic                   other_req;
  logic                   found;
  logic [OW-1:0]          win;
  logic [NUM_MASTERS-1:0] win_grants;
  logic [NUM_MASTERS-1:0] own_mask;
  logic                   bus_idle;
  logic                   frame_low;
  int                     j;

  // X/Z on the shared lines must never look like an idle bus.
  assign bus_idle  = (bus.iframe === 1'b1) && (bus.iready === 1'b1);
  assign frame_low = (bus.iframe === 1'b0);

  // Rotating search: first low request strictly after last, wrapping.
  always_comb begin
    any_req = ~&bus.requests;
    found   = 1'b0;
    win     = '0;
    j       = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = int'(last_q) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!found && !bus.requests[OW'(j)]) begin
        win   = OW'(j);
        found = 1'b1;
      end
    end
    win_grants = ~(ONE << win);
    own_mask   = ONE << owner_q;
    other_req  = |(~bus.requests & ~own_mask);
  end

  always_comb begin
    state_d  = state_q;
    grants_d = grants_q;
    owner_d  = owner_q;
    last_d   = last_q;
`ifdef PCI_ARB_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE, DEAD: begin
        grants_d = ALL_HIGH;
        if (any_req) begin
          grants_d = win_grants;
          owner_d  = win;
          last_d   = win;
          state_d  = GRANT;
`ifdef PCI_ARB_TIMEOUT_EN
          timer_d  = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (frame_low) begin
          state_d = BUSY;
        end else if (bus.requests[owner_q]) begin
          grants_d = ALL_HIGH;
          state_d  = DEAD;
`ifdef PCI_ARB_TIMEOUT_EN
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          grants_d  = ALL_HIGH;
          timeout_d = 1'b1;
          state_d   = DEAD;
        end else begin
          timer_d = timer_q + 8'd1;
`endif
        end
      end
      BUSY: begin
        if (bus_idle) begin
          // A sole requester keeps the bus without a dead cycle.
          if (!bus.requests[owner_q] && !other_req) begin
            state_d = GRANT;
`ifdef PCI_ARB_TIMEOUT_EN
            timer_d = 8'd0;
`endif
          end else begin
            grants_d = ALL_HIGH;
            state_d  = DEAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grants_q <= ALL_HIGH;
      owner_q  <= '0;
      last_q   <= OW'(NUM_MASTERS - 1);
`ifdef PCI_ARB_TIMEOUT_EN
      timer_q   <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
`ifdef PCI_ARB_TIMEOUT_EN
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.grants = grants_q;
  assign owner      = owner_q;
  assign bus_busy   = (state_q == BUSY);
`ifdef PCI_ARB_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule
